// File: rtl/dmem_access_ctrl_if.sv
// Signal bundle between the MEM stage, the debug read port, the data RAM and dmem_access_ctrl.
// slave is the controller's view; master is the view of everything around it.
interface dmem_access_ctrl_if;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [2:0]  cpu_funct3_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ack_o;
    logic        cpu_err_o;
    logic        cpu_stall_o;
    logic        dbg_req_i;
    logic [31:0] dbg_addr_i;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o;
    logic        ram_rd_en_o;
    logic        ram_wr_en_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_funct3_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_ack_o, cpu_err_o, cpu_stall_o,
        input  dbg_req_i, dbg_addr_i,
        output dbg_rdata_o, dbg_ack_o,
        output ram_rd_en_o, ram_wr_en_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_funct3_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_ack_o, cpu_err_o, cpu_stall_o,
        output dbg_req_i, dbg_addr_i,
        input  dbg_rdata_o, dbg_ack_o,
        input  ram_rd_en_o, ram_wr_en_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data RAM sequencer for CPU B/H/W loads/stores (sub-word stores by RMW) and debug reads.
// Ack latency from grant: error 1, SW 2, load/debug 3, SB/SH 4; requesters stall holding req until ack.
module dmem_access_ctrl #(
    parameter int RAM_DEPTH  = 65536,
    parameter int DATA_WIDTH = 32
) (
    input  logic               sys_clk_i,
    input  logic               rst_i,
    dmem_access_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, CPU_RD, LD_CAP, MERGE, CPU_WR, RESP, DBG_RD, DBG_CAP, DBG_RESP
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'(RAM_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [31:0]             addr_q;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    err_q;
    logic                    favour_dbg_q;
    logic [31:0]             cpu_rdata_q;
    logic [31:0]             dbg_rdata_q;

    logic                    grant_cpu, grant_dbg;
    logic                    req_err;
    logic [7:0]              lane_b;
    logic [15:0]             lane_h;
    logic [31:0]             load_ext;
    logic [31:0]             merged;

    // Access check on the live request; only consulted in the grant cycle.
    always_comb begin
        req_err = 1'b0;
        case (bus.cpu_funct3_i)
            3'b011, 3'b110, 3'b111: req_err = 1'b1;
            default: begin
                if (bus.cpu_funct3_i[1:0] == 2'b01 && bus.cpu_addr_i[0])
                    req_err = 1'b1;
                if (bus.cpu_funct3_i[1:0] == 2'b10 && bus.cpu_addr_i[1:0] != 2'b00)
                    req_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req_i && (!bus.dbg_req_i || !favour_dbg_q)) begin
                    grant_cpu = 1'b1;
                    if (req_err)
                        state_d = RESP;
                    else if (bus.cpu_we_i && bus.cpu_funct3_i[1:0] == 2'b10)
                        state_d = CPU_WR;
                    else
                        state_d = CPU_RD;
                end else if (bus.dbg_req_i) begin
                    grant_dbg = 1'b1;
                    state_d   = DBG_RD;
                end
            end
            CPU_RD:   state_d = we_q ? MERGE : LD_CAP;
            LD_CAP:   state_d = RESP;
            MERGE:    state_d = CPU_WR;
            CPU_WR:   state_d = RESP;
            RESP:     state_d = IDLE;
            DBG_RD:   state_d = DBG_CAP;
            DBG_CAP:  state_d = DBG_RESP;
            DBG_RESP: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Lane extraction for loads and lane insertion for sub-word stores.
    always_comb begin
        lane_b = bus.ram_rdata_i[7:0];
        case (addr_q[1:0])
            2'd1:    lane_b = bus.ram_rdata_i[15:8];
            2'd2:    lane_b = bus.ram_rdata_i[23:16];
            2'd3:    lane_b = bus.ram_rdata_i[31:24];
            default: lane_b = bus.ram_rdata_i[7:0];
        endcase
        lane_h = addr_q[1] ? bus.ram_rdata_i[31:16] : bus.ram_rdata_i[15:0];

        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = bus.ram_rdata_i;
        endcase

        merged = bus.ram_rdata_i;
        if (f3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0]  = wdata_q[15:0];
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            favour_dbg_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (grant_cpu) begin
                addr_q       <= bus.cpu_addr_i;
                we_q         <= bus.cpu_we_i;
                f3_q         <= bus.cpu_funct3_i;
                wdata_q      <= bus.cpu_wdata_i;
                err_q        <= req_err;
                favour_dbg_q <= 1'b1;
            end
            if (grant_dbg) begin
                addr_q       <= bus.dbg_addr_i;
                we_q         <= 1'b0;
                err_q        <= 1'b0;
                favour_dbg_q <= 1'b0;
            end
            if (state_q == LD_CAP)  cpu_rdata_q <= load_ext;
            if (state_q == MERGE)   wdata_q     <= merged;
            if (state_q == DBG_CAP) dbg_rdata_q <= bus.ram_rdata_i;
        end
    end

    assign bus.ram_rd_en_o = (state_q == CPU_RD) || (state_q == DBG_RD);
    assign bus.ram_wr_en_o = (state_q == CPU_WR);
    assign bus.ram_addr_o  = {2'b00, addr_q[31:2]} & WORD_MASK;
    assign bus.ram_wdata_o = wdata_q;
    assign bus.cpu_rdata_o = cpu_rdata_q;
    assign bus.cpu_ack_o   = (state_q == RESP);
    assign bus.cpu_err_o   = (state_q == RESP) && err_q;
    assign bus.cpu_stall_o = bus.cpu_req_i && !bus.cpu_ack_o;
    assign bus.dbg_rdata_o = dbg_rdata_q;
    assign bus.dbg_ack_o   = (state_q == DBG_RESP);
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural one-cycle-read data RAM.
module tb_dmem_access_ctrl;
    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.RAM_DEPTH(65536), .DATA_WIDTH(32)) dut (
        .sys_clk_i (clk),
        .rst_i     (rst),
        .bus       (bus)
    );

    logic [31:0] mem [0:1023];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.ram_wr_en_o) mem[bus.ram_addr_o[9:0]] <= bus.ram_wdata_o;
        if (bus.ram_rd_en_o) bus.ram_rdata_i <= mem[bus.ram_addr_o[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the IDLE cycle in which the request is first seen.
    task automatic cpu_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int cyc, output logic err,
                          output logic saw_wr, output logic saw_rd);
        @(negedge clk);
        bus.cpu_req_i    = 1'b1;
        bus.cpu_we_i     = we;
        bus.cpu_funct3_i = f3;
        bus.cpu_addr_i   = addr;
        bus.cpu_wdata_i  = wd;
        cyc = 0; err = 1'b0; saw_wr = 1'b0; saw_rd = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.ram_wr_en_o) saw_wr = 1'b1;
            if (bus.ram_rd_en_o) saw_rd = 1'b1;
            if (bus.cpu_ack_o) begin
                cyc = i;
                err = bus.cpu_err_o;
                break;
            end
        end
        bus.cpu_req_i = 1'b0;
        @(posedge clk);
    endtask

    task automatic dbg_op(input logic [31:0] addr, output int cyc);
        @(negedge clk);
        bus.dbg_req_i  = 1'b1;
        bus.dbg_addr_i = addr;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.dbg_ack_o) begin
                cyc = i;
                break;
            end
        end
        bus.dbg_req_i = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int          cyc;
        logic        err, saw_wr, saw_rd;
        int          order [0:3];
        logic [31:0] dbg_seen [0:1];
        logic [31:0] next_wd;
        int          n_ack, n_dbg;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        rst = 1'b1;
        bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_funct3_i = 3'b000;
        bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
        bus.dbg_req_i = 1'b0; bus.dbg_addr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_ack", {31'd0, bus.cpu_ack_o}, 32'd0);
        check("rst_cpu_err", {31'd0, bus.cpu_err_o}, 32'd0);
        check("rst_dbg_ack", {31'd0, bus.dbg_ack_o}, 32'd0);
        check("rst_rd_en", {31'd0, bus.ram_rd_en_o}, 32'd0);
        check("rst_wr_en", {31'd0, bus.ram_wr_en_o}, 32'd0);
        check("rst_ram_addr", bus.ram_addr_o, 32'd0);
        check("rst_ram_wdata", bus.ram_wdata_o, 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata_o, 32'd0);
        check("rst_dbg_rdata", bus.dbg_rdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load
        cpu_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, cyc, err, saw_wr, saw_rd);
        check("sw_ack_cycle", 32'(cyc), 32'd2);
        check("sw_err", {31'd0, err}, 32'd0);
        check("sw_mem", mem[32'h40], 32'hDEADBEEF);
        cpu_op(1'b0, 3'b010, 32'h100, 32'h0, cyc, err, saw_wr, saw_rd);
        check("lw_ack_cycle", 32'(cyc), 32'd3);
        check("lw_rdata", bus.cpu_rdata_o, 32'hDEADBEEF);

        // Byte read-modify-write and sub-word loads
        mem[32'h10] = 32'h11223344;
        cpu_op(1'b1, 3'b000, 32'h41, 32'h000000AA, cyc, err, saw_wr, saw_rd);
        check("sb_ack_cycle", 32'(cyc), 32'd4);
        check("sb_mem", mem[32'h10], 32'h1122AA44);
        cpu_op(1'b0, 3'b000, 32'h41, 32'h0, cyc, err, saw_wr, saw_rd);
        check("lb_rdata", bus.cpu_rdata_o, 32'hFFFFFFAA);
        cpu_op(1'b0, 3'b100, 32'h41, 32'h0, cyc, err, saw_wr, saw_rd);
        check("lbu_rdata", bus.cpu_rdata_o, 32'h000000AA);

        // Halfword
        mem[32'h10] = 32'h00000000;
        cpu_op(1'b1, 3'b001, 32'h42, 32'h00008001, cyc, err, saw_wr, saw_rd);
        check("sh_ack_cycle", 32'(cyc), 32'd4);
        check("sh_mem", mem[32'h10], 32'h80010000);
        cpu_op(1'b0, 3'b001, 32'h42, 32'h0, cyc, err, saw_wr, saw_rd);
        check("lh_rdata", bus.cpu_rdata_o, 32'hFFFF8001);
        cpu_op(1'b0, 3'b101, 32'h42, 32'h0, cyc, err, saw_wr, saw_rd);
        check("lhu_rdata", bus.cpu_rdata_o, 32'h00008001);

        // Errors: misaligned LW, misaligned SH, illegal funct3
        cpu_op(1'b0, 3'b010, 32'h103, 32'h0, cyc, err, saw_wr, saw_rd);
        check("lw_mis_cycle", 32'(cyc), 32'd1);
        check("lw_mis_err", {31'd0, err}, 32'd1);
        check("lw_mis_ram", {30'd0, saw_wr, saw_rd}, 32'd0);
        check("lw_mis_rdata", bus.cpu_rdata_o, 32'h00008001);
        cpu_op(1'b1, 3'b001, 32'h101, 32'h00001234, cyc, err, saw_wr, saw_rd);
        check("sh_mis_cycle", 32'(cyc), 32'd1);
        check("sh_mis_err", {31'd0, err}, 32'd1);
        check("sh_mis_ram", {30'd0, saw_wr, saw_rd}, 32'd0);
        check("sh_mis_mem", mem[32'h40], 32'hDEADBEEF);
        cpu_op(1'b0, 3'b011, 32'h100, 32'h0, cyc, err, saw_wr, saw_rd);
        check("f3_ill_cycle", 32'(cyc), 32'd1);
        check("f3_ill_err", {31'd0, err}, 32'd1);
        check("f3_ill_ram", {30'd0, saw_wr, saw_rd}, 32'd0);
        check("f3_ill_rdata", bus.cpu_rdata_o, 32'h00008001);

        // Debug read alone
        dbg_op(32'h101, cyc);
        check("dbg_ack_cycle", 32'(cyc), 32'd3);
        check("dbg_rdata", bus.dbg_rdata_o, 32'hDEADBEEF);

        // Contention from reset: CPU first, then strict alternation
        @(negedge clk);
        rst = 1'b1;
        next_wd = 32'hA5A50001;
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_funct3_i = 3'b010;
        bus.cpu_addr_i = 32'h200; bus.cpu_wdata_i = next_wd;
        bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 32'h200;
        for (int i = 0; i < 4; i++) order[i] = -1;
        dbg_seen[0] = '0; dbg_seen[1] = '0;
        n_ack = 0; n_dbg = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60 && n_ack < 4; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack_o) begin
                order[n_ack] = 0;
                n_ack++;
                next_wd = next_wd + 32'd1;
                bus.cpu_wdata_i = next_wd;
            end else if (bus.dbg_ack_o) begin
                order[n_ack] = 1;
                n_ack++;
                if (n_dbg < 2) dbg_seen[n_dbg] = bus.dbg_rdata_o;
                n_dbg++;
            end
        end
        bus.cpu_req_i = 1'b0;
        bus.dbg_req_i = 1'b0;
        @(posedge clk);
        check("arb_0", 32'(order[0]), 32'd0);
        check("arb_1", 32'(order[1]), 32'd1);
        check("arb_2", 32'(order[2]), 32'd0);
        check("arb_3", 32'(order[3]), 32'd1);
        check("arb_dbg_data0", dbg_seen[0], 32'hA5A50001);
        check("arb_dbg_data1", dbg_seen[1], 32'hA5A50002);

        // Reset while an SB sits in MERGE
        mem[32'h10] = 32'h11223344;
        @(negedge clk);
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_funct3_i = 3'b000;
        bus.cpu_addr_i = 32'h40; bus.cpu_wdata_i = 32'h00000055;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rmw_rst_wr_en", {31'd0, bus.ram_wr_en_o}, 32'd0);
        check("rmw_rst_rd_en", {31'd0, bus.ram_rd_en_o}, 32'd0);
        check("rmw_rst_addr", bus.ram_addr_o, 32'd0);
        check("rmw_rst_wdata", bus.ram_wdata_o, 32'd0);
        check("rmw_rst_cpu_rdata", bus.cpu_rdata_o, 32'd0);
        check("rmw_rst_dbg_rdata", bus.dbg_rdata_o, 32'd0);
        check("rmw_rst_ack", {31'd0, bus.cpu_ack_o}, 32'd0);
        bus.cpu_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rmw_rst_mem", mem[32'h10], 32'h11223344);
        cpu_op(1'b1, 3'b010, 32'h40, 32'h12345678, cyc, err, saw_wr, saw_rd);
        check("post_rst_sw_cycle", 32'(cyc), 32'd2);
        check("post_rst_sw_mem", mem[32'h10], 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencer between the MEM stage, the top-level debug read port and the single-port-access data RAM (one-cycle synchronous read, word-wide). It converts RISC-V byte, halfword and word loads/stores into word RAM cycles. Sub-word stores use read-modify-write. It arbitrates the debug reader against the CPU and reports completion and misalignment back to the pipeline.

Parameters:
RAM_DEPTH, 65536, RAM depth in 32-bit words; word index = byte_addr[31:2] mod RAM_DEPTH
DATA_WIDTH, 32, data width; only 32 supported

Ports:
sys_clk_i  in  1  single clock
rst_i  in  1  asynchronous, active-high reset
cpu_req_i  in  1  MEM-stage access request; held with operands until cpu_ack_o
cpu_we_i  in  1  1=store, 0=load
cpu_funct3_i  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
cpu_addr_i  in  32  byte address
cpu_wdata_i  in  32  store data, low-aligned
cpu_rdata_o  out  32  extended load result
cpu_ack_o  out  1  one-cycle completion pulse
cpu_err_o  out  1  high with cpu_ack_o when misaligned or illegal funct3
cpu_stall_o  out  1  cpu_req_i & ~cpu_ack_o (combinational)
dbg_req_i  in  1  top-level word read request; held until dbg_ack_o
dbg_addr_i  in  32  byte address; bits [1:0] ignored
dbg_rdata_o  out  32  debug read data
dbg_ack_o  out  1  one-cycle completion pulse
ram_rd_en_o  out  1  RAM read enable
ram_wr_en_o  out  1  RAM write enable
ram_addr_o  out  32  word index {2'b00, addr[31:2]}
ram_wdata_o  out  32  RAM write data
ram_rdata_i  in  32  RAM read data, valid the cycle after ram_rd_en_o

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, all enables 0, all acks 0, cpu_err_o 0, cpu_rdata_o 0, dbg_rdata_o 0, ram_addr_o 0, ram_wdata_o 0, fairness flag = CPU-favoured.
- States: IDLE, CPU_RD, LD_CAP, MERGE, CPU_WR, RESP, DBG_RD, DBG_CAP, DBG_RESP.
- IDLE arbitration:
  - A single requester wins.
  - If both request, the side not granted last wins. The fairness flag updates on every grant.
  - On grant, latch addr, we, funct3 and wdata. Later input changes are ignored.
- CPU grant, error check: misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) or illegal funct3 (011, 110, 111) goes to RESP with cpu_err_o=1. No RAM access occurs and cpu_rdata_o keeps its value.
- CPU grant, routing: SW goes to CPU_WR. Loads, SB and SH go to CPU_RD.
- CPU_RD: ram_rd_en_o=1. Next state is LD_CAP for loads, MERGE for stores.
- LD_CAP: select the lane by addr[1:0]; sign-extend for B/H, zero-extend for BU/HU, pass through for W. Register into cpu_rdata_o, then go to RESP.
- MERGE: replace byte lane addr[1:0] with wdata[7:0] (SB), or half lane addr[1] with wdata[15:0] (SH). Other bytes keep the RAM value. Register the merged word, then go to CPU_WR.
- CPU_WR: ram_wr_en_o=1 for exactly one cycle with the latched or merged word, then go to RESP.
- RESP: cpu_ack_o=1 (plus cpu_err_o if flagged), then IDLE. The requester drops or changes cpu_req_i after ack; IDLE may accept a new request the following cycle.
- Debug path: DBG_RD (ram_rd_en_o=1), then DBG_CAP (register dbg_rdata_o), then DBG_RESP (dbg_ack_o=1), then IDLE.
- Latency (request high in cycle 0, granted):
  - SW ack in cycle 2.
  - Loads and debug ack in cycle 3.
  - SB/SH ack in cycle 4.
  - Error ack in cycle 1.
- RAM port rules: ram_rd_en_o and ram_wr_en_o are never high together. RAM address and data outputs are driven only from latched values.
- Reset mid-operation: everything returns to reset values. An RMW interrupted before CPU_WR performs no write; no partial write is possible.
- cpu_rdata_o and dbg_rdata_o hold their values until the next successful capture.

Test Plan:
- Store then load: SW 0xDEADBEEF @0x100, then LW @0x100 -> ack cycles 2 and 3; cpu_rdata_o=0xDEADBEEF.
- Byte RMW: RAM[0x40]=0x11223344; SB wdata=0xAA @0x41 -> RAM word 0x1122AA44. Then LB @0x41 -> 0xFFFFFFAA; LBU -> 0x000000AA.
- Halfword: SH 0x8001 @0x42 on 0x00000000 -> 0x80010000. LH @0x42 -> 0xFFFF8001; LHU -> 0x00008001.
- Errors: LW @0x103, SH @0x101, funct3=011 -> each acks in cycle 1 with cpu_err_o=1, no ram_wr_en_o, cpu_rdata_o unchanged.
- Contention: cpu_req_i and dbg_req_i both held from reset -> CPU served first, then debug, then CPU, strictly alternating. dbg_rdata_o shows the word written by the preceding CPU SW.
- Reset during RMW: assert rst_i in MERGE of SB @0x40 -> RAM word unchanged, outputs at reset values, next SW completes normally.
